// File: rtl/and_mxu_seq_pkg.sv
// Shared types and sizing helpers for the sequenced AND-product systolic MXU.
// Imported by the interface, the PE and the top level.
package mxu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Room for a full 2*width product summed dim times, plus sign and wrap headroom.
  function automatic int acc_width(input int width, input int dim);
    return 2 * width + $clog2(dim) + 2;
  endfunction

  // Cycles needed for the last operand pair to reach the far corner PE.
  function automatic int run_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/and_mxu_seq_if.sv
// Job request / result bundle between the operand buffers, the MXU and writeback.
// The requester uses the master view, the MXU the slave view.
interface and_mxu_seq_if
  import mxu_pkg::*;
#(
  parameter int DIM       = 4,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = acc_width(WIDTH, DIM)
) ();

  logic                           start;
  logic                           signed_mode;
  logic                           acc_mode;
  logic [DIM*DIM*WIDTH-1:0]       in0;
  logic [DIM*DIM*WIDTH-1:0]       in1;
  logic [DIM*DIM*ACC_WIDTH-1:0]   out;
  logic                           busy;
  logic                           finished;

  modport master (
    output start,
    output signed_mode,
    output acc_mode,
    output in0,
    output in1,
    input  out,
    input  busy,
    input  finished
  );

  modport slave (
    input  start,
    input  signed_mode,
    input  acc_mode,
    input  in0,
    input  in1,
    output out,
    output busy,
    output finished
  );

endinterface

// File: rtl/and_mxu_seq_pe.sv
// Output-stationary processing element: forwards a east / b south and accumulates
// the product formed from AND partial products (signed or unsigned).
module mxu_pe #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr_acc,
  input  logic                 clr_fwd,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic [ACC_WIDTH-1:0] acc
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]        a_ext;
  logic [PW-1:0]        pp [WIDTH];
  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [ACC_WIDTH-1:0] acc_reg;

  assign a_ext = signed_mode ? {{WIDTH{a_in[WIDTH-1]}}, a_in} : {{WIDTH{1'b0}}, a_in};

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_pp
    assign pp[gi] = (a_ext & {PW{b_in[gi]}}) << gi;
  end

  // In signed mode the multiplier MSB carries weight -2^(WIDTH-1), so its row is subtracted.
  always_comb begin
    prod = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (signed_mode && (i == WIDTH - 1)) begin
        prod = prod - pp[i];
      end else begin
        prod = prod + pp[i];
      end
    end
  end

  assign prod_ext = {{(ACC_WIDTH-PW){signed_mode & prod[PW-1]}}, prod};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (clr_fwd) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (en) begin
      a_reg <= a_in;
      b_reg <= b_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (clr_acc) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + prod_ext;
    end
  end

  assign a_out = a_reg;
  assign b_out = b_reg;
  assign acc   = acc_reg;

endmodule

// File: rtl/and_mxu_seq.sv
// DIM x DIM output-stationary systolic MXU with job controller, on-chip operand
// skewing, signed/unsigned products and optional accumulation across jobs.
module and_mxu_seq
  import mxu_pkg::*;
#(
  parameter int DIM       = 4,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = acc_width(WIDTH, DIM)
) (
  input  logic          clk,
  input  logic          reset,
  and_mxu_seq_if.slave  bus
);

  localparam int              CNT_W    = $clog2(run_cycles(DIM));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(run_cycles(DIM) - 1);

  state_t               state_reg;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [CNT_W-1:0]     cnt_next;
  logic                 accept;
  logic                 run_en;
  logic                 clr_acc;
  logic                 signed_reg;

  logic [WIDTH-1:0]     a_op  [DIM][DIM];
  logic [WIDTH-1:0]     b_op  [DIM][DIM];
  logic [WIDTH-1:0]     west  [DIM];
  logic [WIDTH-1:0]     north [DIM];

  logic [WIDTH-1:0]     a_fwd [DIM][DIM-1];
  logic [WIDTH-1:0]     b_fwd [DIM-1][DIM];
  logic [WIDTH-1:0]     a_drain_unused [DIM];
  logic [WIDTH-1:0]     b_drain_unused [DIM];
  logic [ACC_WIDTH-1:0] acc_q [DIM][DIM];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    run_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        run_en   = 1'b1;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy     = (state_reg != IDLE);
  assign bus.finished = (state_reg == DONE);
  assign clr_acc      = accept & ~bus.acc_mode;

  // Operands are snapshotted on accept so the buffers upstream may change during RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signed_reg <= 1'b0;
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          a_op[r][c] <= '0;
          b_op[r][c] <= '0;
        end
      end
    end else if (accept) begin
      signed_reg <= bus.signed_mode;
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          a_op[r][c] <= bus.in0[(r*DIM+c)*WIDTH +: WIDTH];
          b_op[r][c] <= bus.in1[(r*DIM+c)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Skew: row i is delayed by i cycles and column j by j cycles, zero outside the window.
  always_comb begin
    for (int r = 0; r < DIM; r++) begin
      west[r]  = '0;
      north[r] = '0;
    end
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) begin
        if (int'(cnt_reg) == i + k) begin
          west[i]  = a_op[i][k];
          north[i] = b_op[k][i];
        end
      end
    end
  end

  genvar gi, gj;
  for (gi = 0; gi < DIM; gi++) begin : g_row
    for (gj = 0; gj < DIM; gj++) begin : g_col
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] a_dst;
      logic [WIDTH-1:0] b_dst;

      if (gj == 0) begin : g_a_edge
        assign a_src = west[gi];
      end else begin : g_a_link
        assign a_src = a_fwd[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_src = north[gj];
      end else begin : g_b_link
        assign b_src = b_fwd[gi-1][gj];
      end

      if (gj == DIM - 1) begin : g_a_drain
        assign a_drain_unused[gi] = a_dst;
      end else begin : g_a_pass
        assign a_fwd[gi][gj] = a_dst;
      end

      if (gi == DIM - 1) begin : g_b_drain
        assign b_drain_unused[gj] = b_dst;
      end else begin : g_b_pass
        assign b_fwd[gi][gj] = b_dst;
      end

      mxu_pe #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk         (clk),
        .reset       (reset),
        .en          (run_en),
        .clr_acc     (clr_acc),
        .clr_fwd     (accept),
        .signed_mode (signed_reg),
        .a_in        (a_src),
        .b_in        (b_src),
        .a_out       (a_dst),
        .b_out       (b_dst),
        .acc         (acc_q[gi][gj])
      );

      assign bus.out[(gi*DIM+gj)*ACC_WIDTH +: ACC_WIDTH] = acc_q[gi][gj];
    end
  end

endmodule

// File: tb/tb_and_mxu_seq.sv
// Directed bench for and_mxu_seq: expected result matrices are queued when a job is
// driven and compared when the DUT raises finished.
module tb_and_mxu_seq;
  import mxu_pkg::*;

  localparam int DIM       = 4;
  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = acc_width(WIDTH, DIM);
  localparam int INW       = DIM * DIM * WIDTH;
  localparam int OUTW      = DIM * DIM * ACC_WIDTH;
  localparam int LAT       = 3 * DIM - 1;
  localparam int WIN       = 3 * DIM + 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [OUTW-1:0] sb[$];
  logic [OUTW-1:0] model_acc;

  and_mxu_seq_if #(.DIM(DIM), .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

  and_mxu_seq #(.DIM(DIM), .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint elem(input logic [INW-1:0] m, input int r, input int c, input bit sm);
    logic [WIDTH-1:0] v;
    v = m[(r*DIM+c)*WIDTH +: WIDTH];
    return sm ? longint'($signed(v)) : longint'(v);
  endfunction

  function automatic logic [ACC_WIDTH-1:0] out_el(input logic [OUTW-1:0] v, input int i, input int j);
    return v[(i*DIM+j)*ACC_WIDTH +: ACC_WIDTH];
  endfunction

  function automatic logic [OUTW-1:0] model_job(input logic [OUTW-1:0] prev, input logic [INW-1:0] a,
                                                input logic [INW-1:0] b, input bit sm, input bit am);
    logic [OUTW-1:0]      r;
    logic [ACC_WIDTH-1:0] e;
    r = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        e = am ? out_el(prev, i, j) : '0;
        for (int k = 0; k < DIM; k++) begin
          e = e + ACC_WIDTH'(elem(a, i, k, sm) * elem(b, k, j, sm));
        end
        r[(i*DIM+j)*ACC_WIDTH +: ACC_WIDTH] = e;
      end
    end
    return r;
  endfunction

  function automatic logic [INW-1:0] mat_fill(input logic [WIDTH-1:0] v);
    logic [INW-1:0] m;
    for (int i = 0; i < DIM * DIM; i++) m[i*WIDTH +: WIDTH] = v;
    return m;
  endfunction

  function automatic logic [INW-1:0] mat_ident();
    logic [INW-1:0] m;
    m = '0;
    for (int i = 0; i < DIM; i++) m[(i*DIM+i)*WIDTH +: WIDTH] = WIDTH'(1);
    return m;
  endfunction

  function automatic logic [INW-1:0] mat_ramp();
    logic [INW-1:0] m;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) m[(r*DIM+c)*WIDTH +: WIDTH] = WIDTH'(r * DIM + c);
    return m;
  endfunction

  function automatic logic [INW-1:0] mat_rand();
    logic [INW-1:0] m;
    for (int i = 0; i < DIM * DIM; i++) m[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
    return m;
  endfunction

  // One job: drive start for one edge, watch busy/finished, optionally inject a
  // stray start or an asynchronous reset, then compare the queued expectation.
  task automatic run_job(input string name, input logic [INW-1:0] a, input logic [INW-1:0] b,
                         input bit sm, input bit am, input int inject_cyc, input int reset_cyc);
    logic [OUTW-1:0] exp_v;
    int fin_cyc;
    int pulses;
    bit aborted;
    @(negedge clk);
    bus.in0 = a;
    bus.in1 = b;
    bus.signed_mode = sm;
    bus.acc_mode = am;
    bus.start = 1'b1;
    model_acc = model_job(model_acc, a, b, sm, am);
    sb.push_back(model_acc);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    fin_cyc = 0;
    aborted = 1'b0;
    for (int k = 1; k <= 4 * DIM + 4 && fin_cyc == 0 && !aborted; k++) begin
      @(negedge clk);
      if (k == reset_cyc) begin
        reset = 1'b1;
        #1;
        chk({name, "_rst_out"}, 64'(|bus.out), 64'd0);
        chk({name, "_rst_busy"}, 64'(bus.busy), 64'd0);
        chk({name, "_rst_fin"}, 64'(bus.finished), 64'd0);
        void'(sb.pop_back());
        model_acc = '0;
        aborted = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        chk({name, "_busy"}, 64'(bus.busy), 64'd1);
        if (bus.finished) fin_cyc = k;
        if (k == inject_cyc) begin
          bus.in0 = mat_fill(8'h55);
          bus.in1 = mat_fill(8'h33);
          bus.acc_mode = 1'b1;
          bus.start = 1'b1;
        end else if (k == inject_cyc + 1) begin
          bus.start = 1'b0;
        end
      end
    end
    if (aborted) begin
      $display("job %s: aborted by reset", name);
    end else begin
      chk({name, "_latency"}, 64'(fin_cyc), 64'(LAT));
      exp_v = sb.pop_front();
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++)
          chk($sformatf("%s_c%0d%0d", name, i, j), 64'(out_el(bus.out, i, j)), 64'(out_el(exp_v, i, j)));
      pulses = 0;
      for (int k = 0; k < WIN; k++) begin
        @(negedge clk);
        if (bus.finished) pulses++;
      end
      chk({name, "_extra_fin"}, 64'(pulses), 64'd0);
      chk({name, "_idle_busy"}, 64'(bus.busy), 64'd0);
      chk({name, "_held"}, 64'(bus.out === exp_v), 64'd1);
      $display("job %s: finished in cycle %0d, c00=%0d", name, fin_cyc, out_el(bus.out, 0, 0));
    end
  endtask

  initial begin
    logic [ACC_WIDTH-1:0] neg_lit;
    checks = 0;
    errors = 0;
    model_acc = '0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.acc_mode = 1'b0;
    bus.in0 = '0;
    bus.in1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", 64'(|bus.out), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_fin", 64'(bus.finished), 64'd0);
    reset = 1'b0;

    run_job("ident", mat_ident(), mat_ramp(), 1'b0, 1'b0, 0, 0);
    chk("ident_c23_lit", 64'(out_el(bus.out, 2, 3)), 64'd11);

    run_job("u255", mat_fill(8'hFF), mat_fill(8'hFF), 1'b0, 1'b0, 0, 0);
    chk("u255_lit", 64'(out_el(bus.out, 3, 1)), 64'd260100);

    run_job("zeroA", '0, mat_fill(8'hFF), 1'b0, 1'b0, 0, 0);

    run_job("s_m128sq", mat_fill(8'h80), mat_fill(8'h80), 1'b1, 1'b0, 0, 0);
    chk("s_m128sq_lit", 64'(out_el(bus.out, 1, 2)), 64'd65536);

    run_job("s_m128x127", mat_fill(8'h80), mat_fill(8'h7F), 1'b1, 1'b0, 0, 0);
    neg_lit = ACC_WIDTH'(-65024);
    chk("s_m128x127_lit", 64'(out_el(bus.out, 0, 3)), 64'(neg_lit));

    run_job("u128x127", mat_fill(8'h80), mat_fill(8'h7F), 1'b0, 1'b0, 0, 0);
    chk("u128x127_lit", 64'(out_el(bus.out, 2, 0)), 64'd65024);

    run_job("acc_j1", mat_fill(8'h01), mat_fill(8'h01), 1'b0, 1'b0, 0, 0);
    chk("acc_j1_lit", 64'(out_el(bus.out, 0, 0)), 64'd4);
    run_job("acc_j2", mat_fill(8'h01), mat_fill(8'h01), 1'b0, 1'b1, 0, 0);
    chk("acc_j2_lit", 64'(out_el(bus.out, 3, 3)), 64'd8);
    run_job("acc_j3", mat_fill(8'h01), mat_fill(8'h01), 1'b0, 1'b0, 0, 0);
    chk("acc_j3_lit", 64'(out_el(bus.out, 1, 1)), 64'd4);

    run_job("ignore", mat_ramp(), mat_ident(), 1'b0, 1'b0, 3, 0);

    run_job("rst_mid", mat_ramp(), mat_ramp(), 1'b0, 1'b0, 0, 5);
    run_job("post_rst", mat_rand(), mat_rand(), 1'b1, 1'b0, 0, 0);
    run_job("post_acc", mat_rand(), mat_rand(), 1'b1, 1'b1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/and_mxu_seq.md
Name: and_mxu_seq

Overview:
- Parametrised successor of the output-stationary AND-product systolic MXU: DIM x DIM array computing OUT = A x B.
- Adds what the bare array lacks:
  - a start/busy/done controller;
  - on-chip operand skewing (feeder) and edge zero-fill;
  - a signed/unsigned mode;
  - an accumulate-across-jobs mode.
- Sits between the operand buffers and the result writeback; one job (one matrix product) in flight at a time.

Parameters:
- DIM, 4, array dimension (rows = cols = inner dimension K); DIM >= 2
- WIDTH, 8, operand element width in bits
- ACC_WIDTH, 2*WIDTH+$clog2(DIM)+2, accumulator/result width per element

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  job request; accepted only in IDLE
- signed_mode  in  1  1 = operands two's complement, 0 = unsigned; sampled with start
- acc_mode  in  1  1 = add into existing out, 0 = clear accumulators first; sampled with start
- in0  in  DIM*DIM*WIDTH  matrix A, [row][col][bit]; sampled with start
- in1  in  DIM*DIM*WIDTH  matrix B, [row][col][bit]; sampled with start
- out  out  DIM*DIM*ACC_WIDTH  result C[i][j], registered
- busy  out  1  high from the cycle after accept through the done cycle
- finished  out  1  one-cycle pulse: out valid and final

Behaviour:
- Reset (asynchronous, any time, including mid-job):
  - FSM goes to IDLE; counter and operand registers cleared.
  - All PE accumulators and forwarding registers cleared.
  - out = 0, busy = 0, finished = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1: capture in0, in1, signed_mode and acc_mode. If acc_mode=0, clear all accumulators on the same edge. Set cnt=0 and go to RUN.
  - RUN: cnt increments each cycle. On the edge where cnt = 3*DIM-3, go to DONE.
  - DONE: finished=1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored, with no queueing.
- Feeder (combinational from cnt and captured operands), in RUN cycle t:
  - west input of row i = A[i][t-i] if 0 <= t-i < DIM, else 0;
  - north input of col j = B[t-j][j] if 0 <= t-j < DIM, else 0.
- PE(i,j) per RUN edge:
  - acc += a*b;
  - a is forwarded east and b south through one register each.
  - So PE(i,j) sees k = t-i-j.
  - Accumulators are frozen outside RUN.
- Product is built from AND partial products.
  - Unsigned: zero-extend.
  - Signed: Baugh-Wooley or equivalent. The result must equal the exact two's-complement product, sign-extended to ACC_WIDTH.
- Accumulation is modulo 2^ACC_WIDTH; wrap-around is silent and there is no saturation.
- Latency: start sampled at edge 0 → finished high during cycle 3*DIM-1 (cycle 11 for DIM=4).
- out:
  - continuously drives the accumulators;
  - guaranteed final only from the finished cycle;
  - held unchanged in IDLE until the next accepted start.
- Back-to-back: start may be high in the cycle after finished (IDLE), giving a job every 3*DIM cycles.

Decomposition:
- Package mxu_pkg holds:
  - state enum typedef (IDLE/RUN/DONE);
  - function acc_width(width, dim);
  - function run_cycles(dim) = 3*dim-2.
- Sub-module mxu_pe (parameters WIDTH, ACC_WIDTH) contains:
  - a/b forwarding registers;
  - AND-partial-product multiplier with signed_mode input;
  - accumulator with clear and enable.
- The top level holds the FSM, counter, operand capture, feeder, and a generate grid of mxu_pe.

Test Plan:
- Unsigned, DIM=4, WIDTH=8: A = identity, B[r][c] = 4r+c → out[i][j] = 4i+j; finished exactly 11 cycles after the start edge; busy high cycles 1..11.
- Unsigned extremes: all A = B = 255 → every out = 4*65025 = 260100; all-zero A → out = 0.
- Signed, all A = B = -128 (0x80) → out = 65536. A = -128, B = 127 → out = -65024 (two's complement in ACC_WIDTH). The same 0x80/0x7F bits with signed_mode=0 → 4*128*127 = 65024.
- acc_mode:
  - job 1 (acc_mode=0) with ones matrices → 4;
  - job 2 (acc_mode=1), same operands → 8;
  - job 3 (acc_mode=0) → 4 again.
- start pulsed during RUN with different operands → ignored, result of the first job unchanged, exactly one finished pulse.
- reset asserted at RUN cycle 5 → out, busy and finished go to 0 immediately (asynchronously). A fresh job afterwards gives the correct result with normal latency.
